// File: rtl/mem_defs.sv
// mem_defs: shared op, state and lane-size encodings for the memory access controller
package mem_defs;

    localparam logic [2:0] OP_LW = 3'b000;
    localparam logic [2:0] OP_LH = 3'b001;
    localparam logic [2:0] OP_LB = 3'b010;
    localparam logic [2:0] OP_SW = 3'b100;
    localparam logic [2:0] OP_SH = 3'b101;
    localparam logic [2:0] OP_SB = 3'b110;

    // access size is the low two op bits
    localparam logic [1:0] SZ_W = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_B = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LOAD,
        S_MERGE,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_e;

    // size 2'b11 covers both illegal opcodes (011, 111)
    function automatic logic req_err(input logic [2:0] op, input logic [1:0] a);
        return (op[1:0] == 2'b11) || (op[1:0] == SZ_W && a != 2'b00) || (op[1:0] == SZ_H && a[0]);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: request side and data-memory side of the access controller
interface mem_access_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        addr_err;

    modport master (
        output start, op, addr, wdata, mem_rdata,
        input  mem_addr, mem_wr, mem_wdata, rdata, busy, done, addr_err
    );

    modport slave (
        input  start, op, addr, wdata, mem_rdata,
        output mem_addr, mem_wr, mem_wdata, rdata, busy, done, addr_err
    );
endinterface

// File: rtl/lane_unit.sv
// lane_unit: little-endian byte/half extract and insert on a 32-bit word
module lane_unit
    import mem_defs::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    input  logic [31:0] ins,
    output logic [31:0] ext,
    output logic [31:0] merged
);

    // zero-extended extract for loads, lane replacement for read-modify-write
    always_comb begin
        ext    = word;
        merged = ins;
        if (size == SZ_H) begin
            ext    = lane[1] ? {16'h0, word[31:16]} : {16'h0, word[15:0]};
            merged = lane[1] ? {ins[15:0], word[15:0]} : {word[31:16], ins[15:0]};
        end else if (size == SZ_B) begin
            ext    = {24'h0, word[{lane, 3'b000} +: 8]};
            merged = word;
            merged[{lane, 3'b000} +: 8] = ins[7:0];
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: multicycle load/store sequencer with sub-word read-modify-write
module mem_access_ctrl
    import mem_defs::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input logic clk,
    input logic reset,
    mem_access_ctrl_if.slave bus
);

    localparam logic [1:0] CNT_INIT = 2'(MEM_LATENCY - 1);

    state_e      state;
    logic [2:0]  op_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;
    logic [1:0]  cnt;
    logic [31:0] ext;
    logic [31:0] merged;

    lane_unit u_lane (
        .size   (op_q[1:0]),
        .lane   (lane_q),
        .word   (bus.mem_rdata),
        .ins    (wdata_q),
        .ext    (ext),
        .merged (merged)
    );

    // FSM with all outputs registered; pulses default low every cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            op_q          <= OP_LW;
            lane_q        <= 2'b00;
            wdata_q       <= 32'h0;
            cnt           <= 2'b00;
            bus.mem_addr  <= 32'h0;
            bus.mem_wdata <= 32'h0;
            bus.rdata     <= 32'h0;
            bus.mem_wr    <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.addr_err  <= 1'b0;
        end else begin
            bus.mem_wr   <= 1'b0;
            bus.done     <= 1'b0;
            bus.addr_err <= 1'b0;
            case (state)
                S_IDLE: if (bus.start) begin
                    op_q         <= bus.op;
                    lane_q       <= bus.addr[1:0];
                    wdata_q      <= bus.wdata;
                    bus.mem_addr <= {bus.addr[31:2], 2'b00};
                    cnt          <= CNT_INIT;
                    bus.busy     <= 1'b1;
                    if (req_err(bus.op, bus.addr[1:0])) begin
                        state        <= S_ERR;
                        bus.done     <= 1'b1;
                        bus.addr_err <= 1'b1;
                    end else if (bus.op == OP_SW) begin
                        state         <= S_WRITE;
                        bus.mem_wr    <= 1'b1;
                        bus.mem_wdata <= bus.wdata;
                    end else begin
                        state <= S_READ;
                    end
                end
                S_READ: begin
                    if (cnt == 2'd0) state <= op_q[2] ? S_MERGE : S_LOAD;
                    else cnt <= cnt - 2'd1;
                end
                S_LOAD: begin
                    bus.rdata <= ext;
                    bus.done  <= 1'b1;
                    state     <= S_DONE;
                end
                S_MERGE: begin
                    bus.mem_wdata <= merged;
                    bus.mem_wr    <= 1'b1;
                    state         <= S_WRITE;
                end
                S_WRITE: begin
                    bus.done <= 1'b1;
                    state    <= S_DONE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed checks of load/store timing, lanes, errors and async reset
module tb_mem_access_ctrl;
    import mem_defs::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        start = 1'b0;
    logic        sel = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] word1 = 32'h0;
    logic [31:0] word3 = 32'h0;
    logic [32:0] q1;
    logic [32:0] q3 [3];

    int checks = 0;
    int errors = 0;

    mem_access_ctrl_if b1();
    mem_access_ctrl_if b3();

    assign b1.start = start & ~sel;
    assign b3.start = start & sel;
    assign b1.op = op;
    assign b3.op = op;
    assign b1.addr = addr;
    assign b3.addr = addr;
    assign b1.wdata = wdata;
    assign b3.wdata = wdata;
    assign b1.mem_rdata = (q1[32] && q1[31:0] == b1.mem_addr) ? word1 : 32'hBAD0_BAD0;
    assign b3.mem_rdata = (q3[2][32] && q3[2][31:0] == b3.mem_addr) ? word3 : 32'hBAD0_BAD0;

    // memory model: read data becomes valid MEM_LATENCY cycles after the address
    always @(posedge clk) begin
        q1    <= {b1.busy, b1.mem_addr};
        q3[0] <= {b3.busy, b3.mem_addr};
        q3[1] <= q3[0];
        q3[2] <= q3[1];
    end

    mem_access_ctrl #(.MEM_LATENCY(1)) u_dut1 (.clk(clk), .reset(reset), .bus(b1.slave));
    mem_access_ctrl #(.MEM_LATENCY(3)) u_dut3 (.clk(clk), .reset(reset), .bus(b3.slave));

    logic        o_done, o_wr, o_err, o_busy;
    logic [31:0] o_rdata, o_maddr, o_wd;

    always_comb begin
        o_done  = sel ? b3.done : b1.done;
        o_wr    = sel ? b3.mem_wr : b1.mem_wr;
        o_err   = sel ? b3.addr_err : b1.addr_err;
        o_busy  = sel ? b3.busy : b1.busy;
        o_rdata = sel ? b3.rdata : b1.rdata;
        o_maddr = sel ? b3.mem_addr : b1.mem_addr;
        o_wd    = sel ? b3.mem_wdata : b1.mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int          d_cyc, w_cyc, w_cnt;
    logic [31:0] w_data, r_data, a1;
    logic        e_at_done, busy1;

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd, input bit poke);
        d_cyc = -1;
        w_cyc = -1;
        w_cnt = 0;
        w_data = 32'h0;
        r_data = 32'h0;
        e_at_done = 1'b0;
        @(negedge clk);
        op = o;
        addr = a;
        wdata = wd;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 12 && d_cyc < 0; n++) begin
            if (n == 1) begin
                a1 = o_maddr;
                busy1 = o_busy;
                if (poke) begin
                    op = OP_LW;
                    addr = 32'h40;
                    wdata = 32'h0;
                    start = 1'b1;
                end
            end
            if (o_wr) begin
                w_cnt++;
                w_cyc = n;
                w_data = o_wd;
            end
            if (o_done) begin
                d_cyc = n;
                r_data = o_rdata;
                e_at_done = o_err;
            end
            @(posedge clk);
            #1 start = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_maddr", b1.mem_addr, 32'h0);
        check("rst_wdata_rdata", b1.mem_wdata | b1.rdata, 32'h0);
        check("rst_ctl", {28'h0, b1.mem_wr, b1.busy, b1.done, b1.addr_err}, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        word1 = 32'hDEAD_BEEF;
        run_op(OP_LW, 32'h0000_0010, 32'h0, 1'b0);
        check("lw_maddr", a1, 32'h10);
        check("lw_busy", {31'h0, busy1}, 32'h1);
        check("lw_done_cyc", d_cyc, 32'd3);
        check("lw_rdata", r_data, 32'hDEAD_BEEF);
        check("lw_no_wr", w_cnt, 32'd0);
        check("lw_no_err", {31'h0, e_at_done}, 32'h0);
        check("lw_after", {30'h0, o_done, o_busy}, 32'h0);

        run_op(OP_LB, 32'h0000_0013, 32'h0, 1'b0);
        check("lb_maddr", a1, 32'h10);
        check("lb_rdata", r_data, 32'h0000_00DE);
        check("lb_done_cyc", d_cyc, 32'd3);

        run_op(OP_LH, 32'h0000_0012, 32'h0, 1'b0);
        check("lh_rdata", r_data, 32'h0000_DEAD);
        check("lh_done_cyc", d_cyc, 32'd3);

        word1 = 32'h1111_1111;
        run_op(OP_SB, 32'h0000_0021, 32'h1234_56AA, 1'b0);
        check("sb_maddr", a1, 32'h20);
        check("sb_wr_cyc", w_cyc, 32'd3);
        check("sb_wr_cnt", w_cnt, 32'd1);
        check("sb_wdata", w_data, 32'h1111_AA11);
        check("sb_done_cyc", d_cyc, 32'd4);
        check("sb_rdata_held", r_data, 32'h0000_DEAD);

        run_op(OP_SH, 32'h0000_0022, 32'hFFFF_5678, 1'b0);
        check("sh_wdata", w_data, 32'h5678_1111);
        check("sh_done_cyc", d_cyc, 32'd4);

        run_op(OP_SW, 32'h0000_0004, 32'hCAFE_F00D, 1'b1);
        check("sw_maddr", a1, 32'h4);
        check("sw_wr_cyc", w_cyc, 32'd1);
        check("sw_wdata", w_data, 32'hCAFE_F00D);
        check("sw_done_cyc", d_cyc, 32'd2);
        check("sw_start_ignored", {31'h0, o_busy}, 32'h0);

        run_op(OP_LW, 32'h0000_0002, 32'h0, 1'b0);
        check("lw_mis_done_cyc", d_cyc, 32'd1);
        check("lw_mis_err", {31'h0, e_at_done}, 32'h1);
        check("lw_mis_no_wr", w_cnt, 32'd0);
        check("lw_mis_rdata", r_data, 32'h0000_DEAD);

        run_op(OP_SH, 32'h0000_0003, 32'h0000_BEEF, 1'b0);
        check("sh_mis_done_cyc", d_cyc, 32'd1);
        check("sh_mis_err", {31'h0, e_at_done}, 32'h1);
        check("sh_mis_no_wr", w_cnt, 32'd0);

        run_op(3'b011, 32'h0000_0000, 32'h0, 1'b0);
        check("illegal_done_cyc", d_cyc, 32'd1);
        check("illegal_err", {31'h0, e_at_done}, 32'h1);

        sel = 1'b1;
        word3 = 32'hA5A5_5A5A;
        run_op(OP_LH, 32'h0000_0032, 32'h0, 1'b0);
        check("l3_lh_maddr", a1, 32'h30);
        check("l3_lh_done_cyc", d_cyc, 32'd5);
        check("l3_lh_rdata", r_data, 32'h0000_A5A5);

        @(negedge clk);
        op = OP_SH;
        addr = 32'h0000_0034;
        wdata = 32'h0000_BEEF;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("l3_rst_ctl", {28'h0, o_busy, o_done, o_err, o_wr}, 32'h0);
        check("l3_rst_maddr", o_maddr, 32'h0);
        check("l3_rst_rdata", o_rdata, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        w_cnt = 0;
        repeat (6) begin
            @(posedge clk);
            #1 if (o_wr) w_cnt++;
        end
        check("l3_rst_no_wr", w_cnt, 32'd0);

        run_op(OP_LW, 32'h0000_0030, 32'h0, 1'b0);
        check("l3_lw_done_cyc", d_cyc, 32'd5);
        check("l3_lw_rdata", r_data, 32'hA5A5_5A5A);

        @(negedge clk);
        op = OP_SW;
        addr = 32'h0000_0008;
        wdata = 32'h0000_0001;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("l3_sw_wr", {31'h0, o_wr}, 32'h1);
        #2 reset = 1'b0;
        #1;
        check("l3_sw_rst_wr", {31'h0, o_wr}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
